// File: rtl/wm_plant_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wm_plant_model                                                           |
// | Washer physics model: water level, temperature, drum, door, load cell.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wm_plant_model #(
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned FILL_RATE    = 4,
  parameter int unsigned DRAIN_RATE   = 6,
  parameter int unsigned HEAT_RATE    = 1,
  parameter int unsigned COOL_DIV     = 8,
  parameter int unsigned AMBIENT_TEMP = 20,
  parameter int unsigned MAX_LEVEL    = 200,
  parameter int unsigned MIN_HEAT_LVL = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       water_valve,
  input  logic       drain_valve,
  input  logic       heater,
  input  logic [1:0] motor_speed,
  input  logic [1:0] motor_direction,
  input  logic       door_close_req,
  input  logic       door_open_req,
  input  logic       load_set,
  input  logic [7:0] load_value,
  output logic [7:0] water_level,
  output logic [7:0] temperature,
  output logic [7:0] load_weight,
  output logic       door_closed,
  output logic       door_locked,
  output logic [1:0] drum_speed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       tick
);

  localparam int unsigned C_CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned C_COOL_W = (COOL_DIV > 2) ? $clog2(COOL_DIV) : 1;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_ACCEL   = 2'd1,
    ST_STEADY  = 2'd2,
    ST_DECEL   = 2'd3
  } drum_state_t;

  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic [C_COOL_W-1:0] cool_q, cool_d;
  logic [7:0]          level_q, level_d, temp_q, temp_d, load_q, load_d;
  logic                door_q, door_d, dir_q, dir_d, fault_q, fault_d;
  logic [1:0]          drum_q, drum_d;
  logic [2:0]          code_q, code_d;
  drum_state_t         state_q, state_d;

  logic [9:0] lvl_up, lvl_dn, lvl_diff;
  logic [7:0] lvl_new;
  logic       heat_ok, dir_in, f1, f2, f3;
  logic [1:0] target;

  assign tick        = (cnt_q == C_CNT_W'(TICK_DIV - 1));
  assign water_level = level_q;
  assign temperature = temp_q;
  assign load_weight = load_q;
  assign door_closed = door_q;
  assign door_locked = (drum_q != 2'd0) || (level_q != 8'd0);
  assign drum_speed  = drum_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

  // Level arithmetic in 10 bits so both saturation ends are visible.
  always_comb begin
    lvl_up   = {2'b00, level_q} + (water_valve ? 10'(FILL_RATE) : 10'd0);
    lvl_dn   = drain_valve ? 10'(DRAIN_RATE) : 10'd0;
    lvl_diff = lvl_up - lvl_dn;
    if (lvl_up <= lvl_dn)        lvl_new = 8'd0;
    else if (lvl_diff > 10'd255) lvl_new = 8'd255;
    else                         lvl_new = lvl_diff[7:0];
  end

  assign heat_ok = heater && (level_q >= 8'(MIN_HEAT_LVL));
  assign dir_in  = (motor_direction == 2'd1);
  // A direction change while spinning forces a brake to standstill first.
  assign target  = (!door_q || ((dir_in != dir_q) && (drum_q != 2'd0))) ? 2'd0 : motor_speed;
  assign f1      = tick && (lvl_new > 8'(MAX_LEVEL));
  assign f2      = tick && heater && !heat_ok;
  assign f3      = tick && (motor_speed != 2'd0) && !door_q;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    level_d = level_q;
    temp_d  = temp_q;
    cool_d  = cool_q;
    load_d  = load_q;
    door_d  = door_q;
    dir_d   = dir_q;
    drum_d  = drum_q;
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;

    if (door_close_req)                    door_d = 1'b1;
    else if (door_open_req && !door_locked) door_d = 1'b0;

    if (load_set && (state_q == ST_STOPPED)) load_d = load_value;

    if (tick) begin
      level_d = lvl_new;
      if (heat_ok) begin
        temp_d = (temp_q > 8'(255 - HEAT_RATE)) ? 8'd255 : temp_q + 8'(HEAT_RATE);
        cool_d = '0;
      end else if (cool_q == C_COOL_W'(COOL_DIV - 1)) begin
        cool_d = '0;
        if (temp_q > 8'(AMBIENT_TEMP)) temp_d = temp_q - 8'd1;
      end else begin
        cool_d = cool_q + 1'b1;
      end

      case (state_q)
        ST_STOPPED: begin
          dir_d = dir_in;
          if (target != 2'd0) state_d = ST_ACCEL;
        end
        ST_ACCEL: begin
          if (target > drum_q) begin
            drum_d = drum_q + 2'd1;
            if (drum_q + 2'd1 == target) state_d = ST_STEADY;
          end else if (target < drum_q) begin
            state_d = ST_DECEL;
          end else begin
            state_d = ST_STEADY;
          end
        end
        ST_STEADY: begin
          if (target > drum_q)      state_d = ST_ACCEL;
          else if (target < drum_q) state_d = ST_DECEL;
        end
        default: begin
          if (drum_q == 2'd0) begin
            state_d = ST_STOPPED;
          end else if (target < drum_q) begin
            drum_d = drum_q - 2'd1;
            if (drum_q == 2'd1)               state_d = ST_STOPPED;
            else if (drum_q - 2'd1 == target) state_d = ST_STEADY;
          end else begin
            state_d = ST_STEADY;
          end
        end
      endcase
    end

    // Sticky: only the first event is recorded; lowest code wins a tie.
    if (!fault_q && (f1 || f2 || f3)) begin
      fault_d = 1'b1;
      if (f1)      code_d = 3'd1;
      else if (f2) code_d = 3'd2;
      else         code_d = 3'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      cool_q  <= '0;
      level_q <= 8'd0;
      temp_q  <= 8'(AMBIENT_TEMP);
      load_q  <= 8'd0;
      door_q  <= 1'b0;
      dir_q   <= 1'b0;
      drum_q  <= 2'd0;
      state_q <= ST_STOPPED;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
      level_q <= level_d;
      temp_q  <= temp_d;
      load_q  <= load_d;
      door_q  <= door_d;
      dir_q   <= dir_d;
      drum_q  <= drum_d;
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm_plant_model.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wm_plant_model                                                        |
// | Directed scoreboard bench for the washer plant model.                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wm_plant_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       water_valve, drain_valve, heater;
  logic [1:0] motor_speed, motor_direction;
  logic       door_close_req, door_open_req, load_set;
  logic [7:0] load_value;
  logic [7:0] water_level, temperature, load_weight;
  logic       door_closed, door_locked, fault, tick;
  logic [1:0] drum_speed;
  logic [2:0] fault_code;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  wm_plant_model dut (
    .clk(clk), .rst(rst),
    .water_valve(water_valve), .drain_valve(drain_valve), .heater(heater),
    .motor_speed(motor_speed), .motor_direction(motor_direction),
    .door_close_req(door_close_req), .door_open_req(door_open_req),
    .load_set(load_set), .load_value(load_value),
    .water_level(water_level), .temperature(temperature), .load_weight(load_weight),
    .door_closed(door_closed), .door_locked(door_locked), .drum_speed(drum_speed),
    .fault(fault), .fault_code(fault_code), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input logic [7:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%0d", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
    end
  endtask

  // Returns #1 after the clock edge that applies one physics tick.
  task automatic next_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL tick_timeout observed=%0d expected=1", tick);
    end
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  task automatic pulse_close();
    door_close_req = 1'b1;
    @(posedge clk); #1;
    door_close_req = 1'b0;
  endtask

  // Compares each new drum_speed value against the queued sequence.
  task automatic watch_drum(input int n, input int budget);
    logic [1:0] prev = drum_speed;
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      next_tick();
      t++;
      if (drum_speed !== prev) begin
        check("drum_seq", {6'd0, drum_speed});
        prev = drum_speed;
        seen++;
      end
    end
    if (seen < n) begin
      checks++;
      errors++;
      $error("FAIL drum_timeout observed=%0d expected=%0d", seen, n);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    water_valve = 0; drain_valve = 0; heater = 0;
    motor_speed = 0; motor_direction = 0;
    door_close_req = 0; door_open_req = 0; load_set = 0; load_value = 0;
    #1;
    expect_v(8'd0);  check("rst_level", water_level);
    expect_v(8'd20); check("rst_temp", temperature);
    expect_v(8'd0);  check("rst_load", load_weight);
    expect_v(8'd0);  check("rst_door", {7'd0, door_closed});
    expect_v(8'd0);  check("rst_drum", {6'd0, drum_speed});
    expect_v(8'd0);  check("rst_fault", {7'd0, fault});
    expect_v(8'd0);  check("rst_code", {5'd0, fault_code});
    expect_v(8'd0);  check("rst_tick", {7'd0, tick});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fill and drain with saturation at zero
    pulse_close();
    expect_v(8'd1); check("door_close", {7'd0, door_closed});
    water_valve = 1'b1;
    expect_v(8'd40); ticks(10); check("fill_10", water_level);
    expect_v(8'd1); check("locked_wet", {7'd0, door_locked});
    water_valve = 1'b0; drain_valve = 1'b1;
    expect_v(8'd0); ticks(7); check("drain_sat", water_level);
    drain_valve = 1'b0; water_valve = 1'b1;
    expect_v(8'd8); ticks(2); check("fill_8", water_level);
    water_valve = 1'b0;
    door_open_req = 1'b1; @(posedge clk); #1; door_open_req = 1'b0;
    expect_v(8'd1); check("open_ignored", {7'd0, door_closed});

    // Heating and cooling
    water_valve = 1'b1;
    expect_v(8'd60); ticks(13); check("fill_60", water_level);
    water_valve = 1'b0; heater = 1'b1;
    expect_v(8'd50); ticks(30); check("heat_30", temperature);
    heater = 1'b0;
    expect_v(8'd49); ticks(8); check("cool_8", temperature);
    expect_v(8'd48); ticks(8); check("cool_16", temperature);
    expect_v(8'd0); check("no_fault", {7'd0, fault});

    // Drum acceleration, reversal, load ignored while spinning
    motor_speed = 2'd3; motor_direction = 2'd0;
    expect_v(8'd1); expect_v(8'd2); expect_v(8'd3);
    watch_drum(3, 8);
    load_value = 8'd77; load_set = 1'b1; @(posedge clk); #1; load_set = 1'b0;
    expect_v(8'd0); check("load_ignored", load_weight);
    motor_direction = 2'd1;
    expect_v(8'd2); expect_v(8'd1); expect_v(8'd0);
    expect_v(8'd1); expect_v(8'd2); expect_v(8'd3);
    watch_drum(6, 14);
    water_valve = 1'b1;
    expect_v(8'd100); ticks(10); check("fill_100", water_level);
    water_valve = 1'b0;
    expect_v(8'd3); check("spin_3", {6'd0, drum_speed});

    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    expect_v(8'd0);  check("arst_level", water_level);
    expect_v(8'd0);  check("arst_drum", {6'd0, drum_speed});
    expect_v(8'd20); check("arst_temp", temperature);
    expect_v(8'd0);  check("arst_door", {7'd0, door_closed});
    motor_speed = 2'd0; motor_direction = 2'd0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Load capture while stopped; spin request with door open
    load_value = 8'd77; load_set = 1'b1; @(posedge clk); #1; load_set = 1'b0;
    expect_v(8'd77); check("load_cap", load_weight);
    motor_speed = 2'd2;
    ticks(2);
    expect_v(8'd3); check("code_door", {5'd0, fault_code});
    expect_v(8'd0); check("door_drum", {6'd0, drum_speed});
    motor_speed = 2'd0;
    do_reset();

    // Dry heating
    pulse_close();
    water_valve = 1'b1; ticks(4);
    water_valve = 1'b0; drain_valve = 1'b1;
    expect_v(8'd10); ticks(1); check("level_10", water_level);
    drain_valve = 1'b0; heater = 1'b1;
    ticks(1);
    heater = 1'b0;
    expect_v(8'd2);  check("code_dry", {5'd0, fault_code});
    expect_v(8'd20); check("dry_temp", temperature);
    do_reset();

    // Overflow, sticky against later dry-heat
    pulse_close();
    water_valve = 1'b1;
    ticks(50);
    expect_v(8'd200); check("level_200", water_level);
    expect_v(8'd0);   check("fault_at_max", {7'd0, fault});
    ticks(1);
    expect_v(8'd204); check("level_204", water_level);
    expect_v(8'd1);   check("code_ovf", {5'd0, fault_code});
    water_valve = 1'b0; drain_valve = 1'b1; heater = 1'b1;
    ticks(2);
    drain_valve = 1'b0; heater = 1'b0;
    expect_v(8'd192); check("drain_192", water_level);
    expect_v(8'd1);   check("fault_sticky", {7'd0, fault});
    expect_v(8'd1);   check("code_sticky", {5'd0, fault_code});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
